// File: rtl/priority_encoder_rr_if.sv
// Request/result bundle for the priority encoder: the producer-side request
// vector with its valid/ready pair, and the registered result with its own pair.
interface priority_encoder_rr_if #(
   parameter int N  = 8,
   parameter int CW = 8
);
   localparam int W = $clog2(N);

   logic          mode;
   logic          in_valid;
   logic [N-1:0]  in_vec;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_idx;
   logic [N-1:0]  out_onehot;
   logic          out_multi;
   logic [CW-1:0] multi_cnt;

   modport master (
      output mode, in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_idx, out_onehot, out_multi, multi_cnt
   );

   modport slave (
      input  mode, in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_idx, out_onehot, out_multi, multi_cnt
   );
endinterface

// File: rtl/priority_encoder_rr.sv
// Fixed-priority / round-robin priority encoder with one registered output
// stage, a saturating multi-hot counter and full-throughput valid/ready flow.
module priority_encoder_rr #(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   priority_encoder_rr_if.slave   bus,
   output logic [$clog2(N)-1:0]   dbg_ptr
);
   localparam int W = $clog2(N);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready, and in_ready = !out_valid || out_ready.
   logic          out_valid_q;
   logic [W-1:0]  idx_q;
   logic [N-1:0]  onehot_q;
   logic          multi_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  ptr_q;

   logic          in_ready;
   logic          accept;
   logic          grant_found;
   logic [W-1:0]  grant_idx;
   logic          vec_multi;
   int            start;
   int            pos;

   assign in_ready  = !out_valid_q || bus.out_ready;
   assign accept    = bus.in_valid && in_ready;
   assign vec_multi = |(bus.in_vec & (bus.in_vec - N'(1)));

   // Circular scan from the search start; mode only moves the start point.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      pos         = 0;
      start       = bus.mode ? ((int'(ptr_q) + 1) % N) : 0;
      for (int i = 0; i < N; i++) begin
         pos = (start + i) % N;
         if (!grant_found && bus.in_vec[pos[W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = pos[W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         onehot_q    <= '0;
         multi_q     <= 1'b0;
         cnt_q       <= '0;
         ptr_q       <= W'(N - 1);
      end else if (accept) begin
         if (grant_found) begin
            out_valid_q <= 1'b1;
            idx_q       <= grant_idx;
            onehot_q    <= N'(1) << grant_idx;
            multi_q     <= vec_multi;
            ptr_q       <= grant_idx;
            if (vec_multi && !(&cnt_q)) cnt_q <= cnt_q + CW'(1);
         end else begin
            // An all-zero vector is swallowed; any current result was just taken.
            out_valid_q <= 1'b0;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_idx    = idx_q;
   assign bus.out_onehot = onehot_q;
   assign bus.out_multi  = multi_q;
   assign bus.multi_cnt  = cnt_q;
   assign dbg_ptr        = ptr_q;
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: directed scenarios plus a randomized run
// scored against a circular-distance reference model.
module tb_priority_encoder_rr;
   localparam int N  = 8;
   localparam int W  = 3;
   localparam int CW = 8;
   localparam int QW = W + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   priority_encoder_rr_if #(.N(N), .CW(CW)) bus ();
   priority_encoder_rr_if #(.N(N), .CW(2))  bus2 ();
   logic [W-1:0] dbg_ptr;
   logic [W-1:0] dbg_ptr2;

   priority_encoder_rr #(.N(N), .CW(CW)) dut  (.clk(clk), .rst(rst), .bus(bus),  .dbg_ptr(dbg_ptr));
   priority_encoder_rr #(.N(N), .CW(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_ptr(dbg_ptr2));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic          m_valid;
   int            m_idx;
   logic          m_multi;
   int            m_ptr;
   int            m_cnt;
   logic [QW-1:0] exp_q[$];

   // Granted index = set bit at the smallest circular distance from the search start.
   function automatic int ref_grant(input logic [N-1:0] vec, input logic md, input int p);
      int s, best, bestd, d;
      s = md ? (p + 1) % N : 0;
      best = -1;
      bestd = N;
      for (int k = 0; k < N; k++) begin
         d = (k - s + N) % N;
         if (vec[k] && d < bestd) begin
            best = k;
            bestd = d;
         end
      end
      return best;
   endfunction

   task automatic drive(input logic v, input logic [N-1:0] vec, input logic md, input logic ordy);
      logic acc;
      int g;
      @(negedge clk);
      bus.in_valid = v; bus.in_vec = vec; bus.mode = md; bus.out_ready = ordy;
      acc = v && (!m_valid || ordy);
      @(posedge clk);
      if (acc) begin
         if (vec != '0) begin
            g = ref_grant(vec, md, m_ptr);
            m_idx = g;
            m_multi = ($countones(vec) >= 2);
            m_ptr = g;
            m_valid = 1'b1;
            if (m_multi && m_cnt < (1 << CW) - 1) m_cnt++;
            exp_q.push_back({m_multi, W'(g)});
         end else begin
            m_valid = 1'b0;
         end
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic drive2(input logic v, input logic [N-1:0] vec, input logic ordy);
      @(negedge clk);
      bus2.in_valid = v; bus2.in_vec = vec; bus2.mode = 1'b0; bus2.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.in_vec = N'($urandom); bus.mode = 1'($urandom); bus.out_ready = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      m_valid = 1'b0; m_idx = 0; m_multi = 1'b0; m_ptr = N - 1; m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(2);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
      n_checks++; if (bus.out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx: got %0h want 0", bus.out_idx); end
      n_checks++; if (bus.out_onehot !== '0) begin n_fail++; $display("FAIL reset_out_onehot: got %0h want 0", bus.out_onehot); end
      n_checks++; if (bus.out_multi !== 1'b0) begin n_fail++; $display("FAIL reset_out_multi: got %0h want 0", bus.out_multi); end
      n_checks++; if (bus.multi_cnt !== '0) begin n_fail++; $display("FAIL reset_multi_cnt: got %0h want 0", bus.multi_cnt); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready); end
      n_checks++; if (dbg_ptr !== 3'd7) begin n_fail++; $display("FAIL reset_ptr: got %0h want 7", dbg_ptr); end
      release_reset();
   endtask

   task automatic test_fixed_priority();
      int cnt0;
      drive(1'b1, 8'b0001_0000, 1'b0, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_single_valid: got %0h want 1", bus.out_valid); end
      n_checks++; if (bus.out_idx !== 3'd4) begin n_fail++; $display("FAIL fixed_single_idx: got %0h want 4", bus.out_idx); end
      n_checks++; if (bus.out_onehot !== 8'b0001_0000) begin n_fail++; $display("FAIL fixed_single_onehot: got %0h want 10", bus.out_onehot); end
      n_checks++; if (bus.out_multi !== 1'b0) begin n_fail++; $display("FAIL fixed_single_multi: got %0h want 0", bus.out_multi); end
      cnt0 = int'(bus.multi_cnt);
      drive(1'b1, 8'b1010_0100, 1'b0, 1'b1);
      n_checks++; if (bus.out_idx !== 3'd2) begin n_fail++; $display("FAIL fixed_multi_idx: got %0h want 2", bus.out_idx); end
      n_checks++; if (bus.out_multi !== 1'b1) begin n_fail++; $display("FAIL fixed_multi_flag: got %0h want 1", bus.out_multi); end
      n_checks++; if (int'(bus.multi_cnt) !== cnt0 + 1) begin n_fail++; $display("FAIL fixed_multi_cnt: got %0d want %0d", bus.multi_cnt, cnt0 + 1); end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_rr_wrap();
      logic [W-1:0] want[3];
      want[0] = 3'd0; want[1] = 3'd7; want[2] = 3'd0;
      apply_reset(1);
      release_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'b1000_0001, 1'b1, 1'b1);
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_wrap_valid[%0d]: got %0h want 1", i, bus.out_valid); end
         n_checks++; if (bus.out_idx !== want[i]) begin n_fail++; $display("FAIL rr_wrap_idx[%0d]: got %0d want %0d", i, bus.out_idx, want[i]); end
      end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      drive(1'b1, 8'b0010_0000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, N'($urandom) | 8'h01, 1'($urandom), 1'b0);
         n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0h want 0", i, bus.in_ready); end
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0h want 1", i, bus.out_valid); end
         n_checks++; if (bus.out_idx !== 3'd5 || bus.out_onehot !== 8'b0010_0000 || bus.out_multi !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got idx %0d onehot %0h multi %0h want 5 20 0", i, bus.out_idx, bus.out_onehot, bus.out_multi); end
         n_checks++; if (dbg_ptr !== 3'd5) begin n_fail++; $display("FAIL bp_ptr[%0d]: got %0d want 5", i, dbg_ptr); end
      end
      drive(1'b1, 8'b0000_0110, 1'b0, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd1) begin n_fail++; $display("FAIL bp_release: got valid %0h idx %0d want 1 1", bus.out_valid, bus.out_idx); end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_zero_vector();
      int cnt0;
      drive(1'b1, 8'b0000_1100, 1'b0, 1'b0);
      cnt0 = int'(bus.multi_cnt);
      drive(1'b1, 8'h00, 1'b1, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_clears_valid: got %0h want 0", bus.out_valid); end
      n_checks++; if (int'(bus.multi_cnt) !== cnt0) begin n_fail++; $display("FAIL zero_cnt_hold: got %0d want %0d", bus.multi_cnt, cnt0); end
      n_checks++; if (dbg_ptr !== 3'd2) begin n_fail++; $display("FAIL zero_ptr_hold: got %0d want 2", dbg_ptr); end
      drive(1'b1, 8'h00, 1'b0, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_idle_valid: got %0h want 0", bus.out_valid); end
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      n_checks++; if (bus.out_idx !== 3'd3) begin n_fail++; $display("FAIL zero_then_rr_idx: got %0d want 3", bus.out_idx); end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      logic [N-1:0] vec;
      int want;
      for (int k = 1; k <= 5; k++) begin
         vec = N'($urandom);
         if ($countones(vec) < 2) vec = vec | 8'h81;
         drive2(1'b1, vec, 1'b1);
         want = (k < 3) ? k : 3;
         n_checks++; if (int'(bus2.multi_cnt) !== want) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, bus2.multi_cnt, want); end
      end
      drive2(1'b1, 8'h00, 1'b1);
      n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_zero_valid: got %0h want 0", bus2.out_valid); end
      n_checks++; if (bus2.multi_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_zero_cnt: got %0d want 3", bus2.multi_cnt); end
      drive2(1'b0, '0, 1'b1);
   endtask

   task automatic test_reset_inflight();
      drive(1'b1, 8'b0011_1100, 1'b1, 1'b0);
      drive(1'b1, 8'b0100_0000, 1'b1, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_pending: got %0h want 1", bus.out_valid); end
      apply_reset(1);
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_onehot !== '0 || bus.out_multi !== 1'b0 || bus.multi_cnt !== '0) begin n_fail++; $display("FAIL inflight_reset: got v%0h i%0h o%0h m%0h c%0h want all 0", bus.out_valid, bus.out_idx, bus.out_onehot, bus.out_multi, bus.multi_cnt); end
      release_reset();
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      n_checks++; if (bus.out_idx !== 3'd0 || bus.out_onehot !== 8'h01) begin n_fail++; $display("FAIL inflight_first_rr: got idx %0d onehot %0h want 0 01", bus.out_idx, bus.out_onehot); end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic         v, md, ordy;
      logic [N-1:0] vec;
      logic [QW-1:0] e;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         v    = ($urandom_range(0, 3) != 0);
         md   = 1'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         vec  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         if (m_valid && ordy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_scoreboard_empty: cycle %0d got idx %0d want a queued result", c, bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               if ({bus.out_multi, bus.out_idx} !== e) begin n_fail++; $display("FAIL rand_result: cycle %0d got multi %0h idx %0d want multi %0h idx %0d", c, bus.out_multi, bus.out_idx, e[W], e[W-1:0]); end
            end
         end
         drive(v, vec, md, ordy);
         n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %0h want %0h", c, bus.out_valid, m_valid); end
         n_checks++; if (int'(bus.multi_cnt) !== m_cnt) begin n_fail++; $display("FAIL rand_cnt: cycle %0d got %0d want %0d", c, bus.multi_cnt, m_cnt); end
         n_checks++; if (int'(dbg_ptr) !== m_ptr) begin n_fail++; $display("FAIL rand_ptr: cycle %0d got %0d want %0d", c, dbg_ptr, m_ptr); end
         n_checks++; if (bus.in_ready !== (!m_valid || ordy)) begin n_fail++; $display("FAIL rand_in_ready: cycle %0d got %0h want %0h", c, bus.in_ready, (!m_valid || ordy)); end
         if (m_valid) begin
            n_checks++; if (bus.out_onehot !== (N'(1) << m_idx)) begin n_fail++; $display("FAIL rand_onehot: cycle %0d got %0h want %0h", c, bus.out_onehot, N'(1) << m_idx); end
         end
      end
      drive(1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_vec = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_vec = '0; bus2.mode = 1'b0; bus2.out_ready = 1'b1;
      m_valid = 1'b0; m_idx = 0; m_multi = 1'b0; m_ptr = N - 1; m_cnt = 0;
      test_reset();
      test_saturation();
      test_fixed_priority();
      test_rr_wrap();
      test_backpressure();
      test_zero_vector();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
